// File: rtl/sci_event_counter_pkg.sv
// Shared constants and constant functions for the scientific-notation event counter.
// Optional BCD mirror of the mantissa is enabled with SCI_EVENT_COUNTER_BCD_EN.
package sci_event_counter_pkg;

    function automatic logic [39:0] pow10(input int n);
        logic [39:0] r;
        r = 40'd1;
        for (int i = 0; i < n; i++) r = r * 40'd10;
        return r;
    endfunction

    // Bits needed to hold values 0 .. v-1.
    function automatic int clog2(input logic [39:0] v);
        logic [39:0] x;
        int r;
        x = v - 40'd1;
        r = 0;
        for (int i = 0; i < 40; i++) if (x[i]) r = i + 1;
        return r;
    endfunction

    // Prescaler wrap point for a given exponent: 10^e - 1.
    function automatic logic [39:0] thr_of(input int e);
        return pow10(e) - 40'd1;
    endfunction

    localparam int DEF_MANT_DIGITS = 2;
    localparam int DEF_MAX_EXP     = 9;
    localparam int TOP    = int'(pow10(DEF_MANT_DIGITS));
    localparam int LOW    = int'(pow10(DEF_MANT_DIGITS - 1));
    localparam int MANT_W = clog2(pow10(DEF_MANT_DIGITS));
    localparam int PRE_W  = clog2(pow10(DEF_MAX_EXP));

endpackage

// File: rtl/sci_event_counter_prescaler.sv
// Decade prescaler: divides qualified events by 10^exponent and ticks the mantissa stage.
// Used by sci_event_counter in every build (independent of SCI_EVENT_COUNTER_BCD_EN).
module sci_prescaler
    import sci_event_counter_pkg::*;
#(
    parameter int MAX_EXP = 9,
    parameter int EXP_W   = 4,
    parameter int PRE_W   = 30
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [EXP_W-1:0] exp_i,
    input  logic             en_i,
    input  logic             clr_i,
    output logic             at_thr_o,
    output logic             tick_o
);

    logic [PRE_W-1:0] thr_tab [MAX_EXP+1];
    logic [PRE_W-1:0] thr;
    logic [PRE_W-1:0] pre_q, pre_d;

    for (genvar g = 0; g <= MAX_EXP; g++) begin : g_thr
        assign thr_tab[g] = PRE_W'(thr_of(g));
    end

    always_comb begin
        thr = '0;
        for (int i = 0; i <= MAX_EXP; i++)
            if (exp_i == EXP_W'(i)) thr = thr_tab[i];
    end

    // At exponent 0 the threshold is 0, so every event ticks straight through.
    assign at_thr_o = (pre_q == thr);
    assign tick_o   = en_i & at_thr_o;

    always_comb begin
        pre_d = pre_q;
        if (clr_i)     pre_d = '0;
        else if (en_i) pre_d = at_thr_o ? '0 : pre_q + PRE_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pre_q <= '0;
        else        pre_q <= pre_d;
    end

endmodule

// File: rtl/sci_event_counter.sv
// Event counter reporting mantissa x 10^exponent with saturation, clear and snapshot.
// Define SCI_EVENT_COUNTER_BCD_EN to add the packed-BCD mantissa outputs mant_bcd/snap_bcd.
module sci_event_counter
    import sci_event_counter_pkg::*;
#(
    parameter int MANT_DIGITS = 2,
    parameter int MAX_EXP     = 9,
    parameter int EXP_W       = 4,
    localparam int M_W        = clog2(pow10(MANT_DIGITS))
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     clr,
    input  logic                     snap,
    output logic [M_W-1:0]           mantissa,
    output logic [EXP_W-1:0]         exponent,
    output logic                     ovf,
    output logic [M_W-1:0]           snap_mant,
    output logic [EXP_W-1:0]         snap_exp,
`ifdef SCI_EVENT_COUNTER_BCD_EN
    output logic [4*MANT_DIGITS-1:0] mant_bcd,
    output logic [4*MANT_DIGITS-1:0] snap_bcd,
`endif
    output logic                     snap_valid
);

    localparam int CNT_TOP = int'(pow10(MANT_DIGITS));
    localparam int CNT_LOW = int'(pow10(MANT_DIGITS - 1));
    localparam int P_W     = clog2(pow10(MAX_EXP));

    logic [M_W-1:0]   mant_q, mant_d, smant_q;
    logic [EXP_W-1:0] exp_q, exp_d, sexp_q;
    logic             ovf_q, ovf_d, sval_q;
    logic             ev, at_max, at_thr, sat, pre_en, tick;

    assign ev     = en & ~clr & ~ovf_q;
    assign at_max = (exp_q == EXP_W'(MAX_EXP)) & (mant_q == M_W'(CNT_TOP - 1));
    assign sat    = ev & at_max & at_thr;
    // The saturating event must not move the prescaler, so it is withheld here.
    assign pre_en = ev & ~sat;

    sci_prescaler #(
        .MAX_EXP (MAX_EXP),
        .EXP_W   (EXP_W),
        .PRE_W   (P_W)
    ) u_pre (
        .clk      (clk),
        .rst_n    (rst_n),
        .exp_i    (exp_q),
        .en_i     (pre_en),
        .clr_i    (clr),
        .at_thr_o (at_thr),
        .tick_o   (tick)
    );

    always_comb begin
        mant_d = mant_q;
        exp_d  = exp_q;
        ovf_d  = ovf_q;
        if (clr) begin
            mant_d = '0;
            exp_d  = '0;
            ovf_d  = 1'b0;
        end else if (sat) begin
            ovf_d = 1'b1;
        end else if (tick) begin
            if (mant_q == M_W'(CNT_TOP - 1)) begin
                mant_d = M_W'(CNT_LOW);
                exp_d  = exp_q + EXP_W'(1);
            end else begin
                mant_d = mant_q + M_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mant_q  <= '0;
            exp_q   <= '0;
            ovf_q   <= 1'b0;
            smant_q <= '0;
            sexp_q  <= '0;
            sval_q  <= 1'b0;
        end else begin
            mant_q <= mant_d;
            exp_q  <= exp_d;
            ovf_q  <= ovf_d;
            sval_q <= snap;
            if (snap) begin
                smant_q <= mant_q;
                sexp_q  <= exp_q;
            end
        end
    end

    assign mantissa   = mant_q;
    assign exponent   = exp_q;
    assign ovf        = ovf_q;
    assign snap_mant  = smant_q;
    assign snap_exp   = sexp_q;
    assign snap_valid = sval_q;

`ifdef SCI_EVENT_COUNTER_BCD_EN
    localparam logic [4*MANT_DIGITS-1:0] BCD_LOW = (4*MANT_DIGITS)'(1) << (4*(MANT_DIGITS-1));

    function automatic logic [4*MANT_DIGITS-1:0] bcd_inc(input logic [4*MANT_DIGITS-1:0] v);
        logic [4*MANT_DIGITS-1:0] r;
        logic                     c;
        r = v;
        c = 1'b1;
        for (int d = 0; d < MANT_DIGITS; d++) begin
            if (c) begin
                if (v[4*d +: 4] == 4'd9) r[4*d +: 4] = 4'd0;
                else begin
                    r[4*d +: 4] = v[4*d +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    logic [4*MANT_DIGITS-1:0] bcd_q, bcd_d, sbcd_q;

    // Mirrors the binary mantissa update decision-for-decision.
    always_comb begin
        bcd_d = bcd_q;
        if (clr)       bcd_d = '0;
        else if (!sat && tick)
            bcd_d = (mant_q == M_W'(CNT_TOP - 1)) ? BCD_LOW : bcd_inc(bcd_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q  <= '0;
            sbcd_q <= '0;
        end else begin
            bcd_q <= bcd_d;
            if (snap) sbcd_q <= bcd_q;
        end
    end

    assign mant_bcd = bcd_q;
    assign snap_bcd = sbcd_q;
`endif

endmodule

// File: tb/tb_sci_event_counter.sv
// Bench for sci_event_counter: default instance, a MAX_EXP=2 instance and, with
// SCI_EVENT_COUNTER_BCD_EN, a 3-digit instance; all share one stimulus stream.
module tb_sci_event_counter;

    logic clk = 1'b0;
    logic rst_n, en, clr, snap;

    logic [6:0] mant_a, smant_a, mant_b, smant_b;
    logic [3:0] exp_a, sexp_a, exp_b, sexp_b;
    logic       ovf_a, sval_a, ovf_b, sval_b;

    always #5 clk = ~clk;

    sci_event_counter u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .snap(snap),
        .mantissa(mant_a), .exponent(exp_a), .ovf(ovf_a),
        .snap_mant(smant_a), .snap_exp(sexp_a),
`ifdef SCI_EVENT_COUNTER_BCD_EN
        .mant_bcd(), .snap_bcd(),
`endif
        .snap_valid(sval_a)
    );

    sci_event_counter #(.MANT_DIGITS(2), .MAX_EXP(2), .EXP_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .snap(snap),
        .mantissa(mant_b), .exponent(exp_b), .ovf(ovf_b),
        .snap_mant(smant_b), .snap_exp(sexp_b),
`ifdef SCI_EVENT_COUNTER_BCD_EN
        .mant_bcd(), .snap_bcd(),
`endif
        .snap_valid(sval_b)
    );

`ifdef SCI_EVENT_COUNTER_BCD_EN
    logic [9:0]  mant_c, smant_c;
    logic [3:0]  exp_c, sexp_c;
    logic        ovf_c, sval_c;
    logic [11:0] bcd_c, sbcd_c;

    sci_event_counter #(.MANT_DIGITS(3), .MAX_EXP(2), .EXP_W(4)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .snap(snap),
        .mantissa(mant_c), .exponent(exp_c), .ovf(ovf_c),
        .snap_mant(smant_c), .snap_exp(sexp_c),
        .mant_bcd(bcd_c), .snap_bcd(sbcd_c),
        .snap_valid(sval_c)
    );
`endif

    // Reference model: total event count per instance, saturating at TOP*10^MAX_EXP.
    int     MD [3] = '{2, 2, 3};
    int     MX [3] = '{9, 2, 2};
    longint n  [3];
    int     sm [3];
    int     se [3];
    bit     sv;
    int     n_pass = 0;
    int     n_total = 0;

    function automatic longint lim_of(input int k);
        longint l = 1;
        for (int i = 0; i < MD[k] + MX[k]; i++) l = l * 10;
        return l;
    endfunction

    // Smallest exponent whose scaled count fits in MANT_DIGITS digits.
    function automatic void sci(input int k, output int m, output int e, output bit o);
        longint top = 1;
        longint q;
        for (int i = 0; i < MD[k]; i++) top = top * 10;
        o = (n[k] >= lim_of(k));
        q = o ? lim_of(k) - 1 : n[k];
        e = 0;
        while (q >= top) begin
            q = q / 10;
            e++;
        end
        m = int'(q);
    endfunction

    function automatic logic [11:0] live_of(input int k);
        int m, e;
        bit o;
        sci(k, m, e, o);
        return {7'(m), 4'(e), o};
    endfunction

    function automatic logic [11:0] snap_of(input int k);
        return {7'(sm[k]), 4'(se[k]), sv};
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            n[k] = 0; sm[k] = 0; se[k] = 0;
        end
        sv = 1'b0;
    endtask

    task automatic step(input bit e_, input bit c_, input bit s_);
        int m, ex;
        bit o;
        en = e_; clr = c_; snap = s_;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (s_) begin
                sci(k, m, ex, o);
                sm[k] = m; se[k] = ex;
            end
            if (c_) n[k] = 0;
            else if (e_ && n[k] < lim_of(k)) n[k] = n[k] + 1;
        end
        sv = s_;
        #1;
    endtask

    task automatic run(input int cnt);
        for (int i = 0; i < cnt; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; snap = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({mant_a, exp_a, ovf_a, smant_a, sexp_a, sval_a} !== 24'h0)
            $display("FAIL reset_state got=%h want=0", {mant_a, exp_a, ovf_a, smant_a, sexp_a, sval_a});
        else n_pass++;
        rst_n = 1'b1;
        run(3);
        step(1'b1, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({mant_a, exp_a, ovf_a, smant_a, sexp_a, sval_a, mant_b, exp_b, sval_b} !== 36'h0)
            $display("FAIL async_reset got a=%h b=%h want=0",
                     {mant_a, exp_a, ovf_a, smant_a, sexp_a, sval_a}, {mant_b, exp_b, sval_b});
        else n_pass++;
        model_reset();
        #1 rst_n = 1'b1;
        run(5);
        n_total++;
        if ({mant_a, exp_a, ovf_a} !== {7'd5, 4'd0, 1'b0})
            $display("FAIL post_reset_5 got=%0d/%0d want=5/0", mant_a, exp_a);
        else n_pass++;
    endtask

    task automatic test_rollover();
        step(1'b0, 1'b1, 1'b0);
        run(99);
        n_total++;
        if ({mant_a, exp_a, ovf_a} !== {7'd99, 4'd0, 1'b0})
            $display("FAIL roll_99 got=%0d/%0d want=99/0", mant_a, exp_a);
        else n_pass++;
        run(1);
        n_total++;
        if ({mant_a, exp_a, ovf_a, mant_b, exp_b} !== {7'd10, 4'd1, 1'b0, 7'd10, 4'd1})
            $display("FAIL roll_100 got a=%0d/%0d b=%0d/%0d want=10/1", mant_a, exp_a, mant_b, exp_b);
        else n_pass++;
        run(10);
        n_total++;
        if ({mant_a, exp_a} !== {7'd11, 4'd1})
            $display("FAIL roll_110 got=%0d/%0d want=11/1", mant_a, exp_a);
        else n_pass++;
        run(890);
        n_total++;
        if ({mant_a, exp_a, mant_b, exp_b} !== {7'd10, 4'd2, 7'd10, 4'd2})
            $display("FAIL roll_1000 got a=%0d/%0d b=%0d/%0d want=10/2", mant_a, exp_a, mant_b, exp_b);
        else n_pass++;
    endtask

    task automatic test_saturation();
        step(1'b0, 1'b1, 1'b0);
        run(9999);
        n_total++;
        if ({mant_b, exp_b, ovf_b} !== {7'd99, 4'd2, 1'b0})
            $display("FAIL sat_9999 got=%0d/%0d ovf=%0b want=99/2 ovf=0", mant_b, exp_b, ovf_b);
        else n_pass++;
        run(1);
        n_total++;
        if ({mant_b, exp_b, ovf_b} !== {7'd99, 4'd2, 1'b1})
            $display("FAIL sat_10000 got=%0d/%0d ovf=%0b want=99/2 ovf=1", mant_b, exp_b, ovf_b);
        else n_pass++;
        n_total++;
        if ({mant_a, exp_a, ovf_a} !== live_of(0))
            $display("FAIL sat_default got=%h want=%h", {mant_a, exp_a, ovf_a}, live_of(0));
        else n_pass++;
        run(50);
        n_total++;
        if ({mant_b, exp_b, ovf_b} !== {7'd99, 4'd2, 1'b1})
            $display("FAIL sat_hold got=%0d/%0d ovf=%0b want=99/2 ovf=1", mant_b, exp_b, ovf_b);
        else n_pass++;
    endtask

    task automatic test_clear();
        step(1'b0, 1'b1, 1'b0);
        run(42);
        step(1'b1, 1'b1, 1'b0);
        n_total++;
        if ({mant_a, exp_a, ovf_a} !== 12'h0)
            $display("FAIL clr_over_en got=%0d/%0d want=0/0", mant_a, exp_a);
        else n_pass++;
        run(9999);
        step(1'b1, 1'b1, 1'b0);
        n_total++;
        if ({mant_b, exp_b, ovf_b} !== 12'h0)
            $display("FAIL clr_at_sat got=%0d/%0d ovf=%0b want=0/0 ovf=0", mant_b, exp_b, ovf_b);
        else n_pass++;
        run(10000);
        n_total++;
        if (ovf_b !== 1'b1)
            $display("FAIL clr_resat got ovf=%0b want=1", ovf_b);
        else n_pass++;
        step(1'b0, 1'b1, 1'b0);
        n_total++;
        if ({mant_b, exp_b, ovf_b} !== 12'h0)
            $display("FAIL clr_after_ovf got=%0d/%0d ovf=%0b want=0/0 ovf=0", mant_b, exp_b, ovf_b);
        else n_pass++;
        run(3);
        n_total++;
        if ({mant_b, exp_b, ovf_b} !== {7'd3, 4'd0, 1'b0})
            $display("FAIL clr_recount got=%0d/%0d want=3/0", mant_b, exp_b);
        else n_pass++;
    endtask

    task automatic test_snapshot();
        step(1'b0, 1'b1, 1'b0);
        run(370);
        step(1'b1, 1'b0, 1'b1);
        n_total++;
        if ({smant_a, sexp_a, sval_a} !== {7'd37, 4'd1, 1'b1})
            $display("FAIL snap_capture got=%0d/%0d v=%0b want=37/1 v=1", smant_a, sexp_a, sval_a);
        else n_pass++;
        step(1'b1, 1'b0, 1'b0);
        n_total++;
        if ({smant_a, sexp_a, sval_a} !== {7'd37, 4'd1, 1'b0})
            $display("FAIL snap_pulse got=%0d/%0d v=%0b want=37/1 v=0", smant_a, sexp_a, sval_a);
        else n_pass++;
        run(8);
        n_total++;
        if ({mant_a, exp_a} !== {7'd38, 4'd1})
            $display("FAIL snap_live_adv got=%0d/%0d want=38/1", mant_a, exp_a);
        else n_pass++;
        step(1'b1, 1'b1, 1'b1);
        n_total++;
        if ({smant_a, sexp_a, sval_a, mant_a, exp_a} !== {7'd38, 4'd1, 1'b1, 7'd0, 4'd0})
            $display("FAIL snap_with_clr got snap=%0d/%0d live=%0d/%0d want snap=38/1 live=0/0",
                     smant_a, sexp_a, mant_a, exp_a);
        else n_pass++;
    endtask

    task automatic test_random();
        step(1'b0, 1'b1, 1'b0);
        run(9985);
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(3, 0) != 0, $urandom_range(63, 0) == 0, $urandom_range(7, 0) == 0);
            n_total++;
            if ({mant_a, exp_a, ovf_a, smant_a, sexp_a, sval_a} !== {live_of(0), snap_of(0)})
                $display("FAIL rand_a cyc=%0d got=%h want=%h", i,
                         {mant_a, exp_a, ovf_a, smant_a, sexp_a, sval_a}, {live_of(0), snap_of(0)});
            else n_pass++;
            n_total++;
            if ({mant_b, exp_b, ovf_b, smant_b, sexp_b, sval_b} !== {live_of(1), snap_of(1)})
                $display("FAIL rand_b cyc=%0d got=%h want=%h", i,
                         {mant_b, exp_b, ovf_b, smant_b, sexp_b, sval_b}, {live_of(1), snap_of(1)});
            else n_pass++;
`ifdef SCI_EVENT_COUNTER_BCD_EN
            begin
                int m, e;
                bit o;
                sci(2, m, e, o);
                n_total++;
                if ({mant_c, exp_c, bcd_c, sbcd_c} !== {10'(m), 4'(e), to_bcd(m), to_bcd(sm[2])})
                    $display("FAIL rand_bcd cyc=%0d got=%0d/%0d bcd=%h sbcd=%h want=%0d/%0d bcd=%h sbcd=%h",
                             i, mant_c, exp_c, bcd_c, sbcd_c, m, e, to_bcd(m), to_bcd(sm[2]));
                else n_pass++;
            end
`endif
        end
    endtask

`ifdef SCI_EVENT_COUNTER_BCD_EN
    task automatic test_bcd();
        step(1'b0, 1'b1, 1'b0);
        run(999);
        n_total++;
        if ({mant_c, exp_c, bcd_c} !== {10'd999, 4'd0, 12'h999})
            $display("FAIL bcd_999 got=%0d/%0d bcd=%h want=999/0 bcd=999", mant_c, exp_c, bcd_c);
        else n_pass++;
        run(1);
        n_total++;
        if ({mant_c, exp_c, bcd_c} !== {10'd100, 4'd1, 12'h100})
            $display("FAIL bcd_roll got=%0d/%0d bcd=%h want=100/1 bcd=100", mant_c, exp_c, bcd_c);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_rollover();
        test_saturation();
        test_clear();
        test_snapshot();
`ifdef SCI_EVENT_COUNTER_BCD_EN
        test_bcd();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sci_event_counter.md
Name: sci_event_counter

Overview:
- Parametrised event counter that reports its count in scientific notation: mantissa × 10^exponent.
- Generalises the fixed two-digit log counter by adding:
  - configurable mantissa digits and maximum exponent;
  - saturation with a sticky overflow flag;
  - synchronous clear;
  - a snapshot register for glitch-free readout by the display/UART path.
- Sits between the event source (debounced pulse or enable strobe) and the display formatter.

Parameters:
- MANT_DIGITS, 2: decimal digits in the mantissa (1..4).
- MAX_EXP, 9: highest exponent reached before saturation (1..9).
- EXP_W, 4: exponent output width; must satisfy 2^EXP_W > MAX_EXP.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  one event per cycle when high.
- clr  in  1  synchronous clear of the count and the overflow flag.
- snap  in  1  latch the current value into the snapshot outputs.
- mantissa  out  MANT_W  live mantissa. MANT_W = clog2(10^MANT_DIGITS).
- exponent  out  EXP_W  live exponent.
- ovf  out  1  sticky saturation flag.
- snap_mant  out  MANT_W  snapshot of mantissa.
- snap_exp  out  EXP_W  snapshot of exponent.
- snap_valid  out  1  single-cycle pulse, asserted the cycle after a snap.

Behaviour:
- Constants:
  - TOP = 10^MANT_DIGITS
  - LOW = 10^(MANT_DIGITS-1)
  - prescaler width PRE_W = clog2(10^MAX_EXP)
- Reset (rst_n low, asynchronous): mantissa, exponent, prescaler, ovf, snap_mant, snap_exp and snap_valid are all 0.
- Event handling when en=1, clr=0 and ovf=0:
  - Exponent 0: mantissa increments on every event.
  - Exponent e>0: the prescaler increments on each event. When the prescaler equals 10^e−1, it returns to 0 and the mantissa increments.
  - Mantissa rollover: when an increment would make the mantissa equal TOP, the mantissa becomes LOW, the exponent increments and the prescaler is 0.
  - Saturation: exponent==MAX_EXP, mantissa==TOP−1, prescaler at its threshold and a qualifying event arrives. Result: ovf sets, while mantissa, exponent and prescaler hold at their current values.
- Overflow hold: while ovf=1, en is ignored. All state holds until clr or reset.
- Clear (clr=1): on the next edge, mantissa, exponent, prescaler and ovf return to 0. clr has priority over en in the same cycle. Snapshot registers are unaffected.
- Snapshot (snap=1):
  - On the next edge, snap_mant and snap_exp take the pre-edge live values. If en is also high, the snapshot is the value before that event is counted.
  - snap_valid is high for exactly that one following cycle.
  - If snap and clr are both high, the snapshot takes the pre-clear value.
- Timing: all live outputs are registered, so the updated value appears one cycle after the event edge. No combinational path from any input to any output.
- Threshold compare: use a per-exponent constant table (10^e−1). No runtime exponentiation.

Optional Feature:
- Macro: SCI_EVENT_COUNTER_BCD_EN.
- Defined:
  - Adds output mant_bcd [4*MANT_DIGITS-1:0], a packed-BCD image of mantissa maintained as a parallel BCD counter.
  - It follows the same increment, rollover-to-LOW, clear and reset rules as mantissa and always matches it cycle for cycle.
  - snap_bcd is added alongside snap_mant and captured on the same snap edge.
- Undefined: neither port exists and no BCD logic is synthesised.

Decomposition:
- Package sci_event_counter_pkg holds:
  - function pow10(n), returning a 40-bit constant;
  - function clog2;
  - localparams TOP, LOW, MANT_W, PRE_W;
  - the threshold table generator, a constant function indexed by exponent.
- One sub-module, sci_prescaler:
  - inputs: exponent, en, clr;
  - compares against the table and emits a one-cycle tick to the mantissa stage;
  - owns the prescaler register.
- Mantissa, exponent, overflow and snapshot logic stay in the top level.

Test Plan:
- Reset: assert rst_n=0 mid-count, with no clock edge required. Expected: all outputs 0 immediately. Release rst_n, then 5 events → mantissa=5, exponent=0.
- Defaults, first rollover: 99 events → 99/0. Event 100 → 10/1. A further 10 events → 11/1. A further 890 events → 10/2.
- MAX_EXP=2 saturation: 9999 events → 99/2, ovf=0. Event 10000 → ovf=1, value stays 99/2. 50 more events → unchanged.
- Clear:
  - Assert clr with en high at 42/0 → next cycle 0/0. clr in the same cycle as the saturation event → 0/0 and ovf=0.
  - After saturation (ovf=1), pulse clr alone → 0/0, ovf=0. The counter then counts again.
- Snapshot: at 37/1, pulse snap with en high. Expected: snap_mant=37, snap_exp=1, snap_valid high for exactly one cycle, and the live value keeps advancing.
- With SCI_EVENT_COUNTER_BCD_EN and MANT_DIGITS=3: across the 999→100 rollover, mant_bcd goes 0x999 → 0x100. mant_bcd equals the BCD of mantissa on every cycle of a randomised en stream.
